jtag_master: RTL
================

# jtag_master

Host-side JTAG driver: converts scan commands into TCK/TMS/TDI waveforms for an IEEE 1149.1 TAP and collects TDO. It sits between the debug/bridge logic and the TAP pins; in simulation it drives the project TAP model directly. The block walks the TAP state machine for IR scans, DR scans, idle cycles and logic reset, and returns captured TDO data per command.

## Interface
- CLK_DIV, 2: clk_i cycles per TCK half-period, ≥1.
- MAX_LEN, 64: maximum scan length in bits, and the width of the data paths.
- clk_i  in  1  system clock
- ntrst_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_type_i  in  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 idle cycles
- cmd_len_i  in  7  bits to shift (scans) or TCK count (idle)
- cmd_data_i  in  MAX_LEN  TDI data, bit 0 shifted first
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  MAX_LEN  captured TDO, bit i = TDO during shift bit i
- tck_o / tms_o / tdi_o  out  1 each  JTAG pins
- tdo_i  in  1  JTAG TDO
- busy_o  out  1  high whenever not in IDLE

## Operation
- One clock; reset is asynchronous and active-low; all state is in the clk_i domain.
- TCK generator: divider counter 0..CLK_DIV-1; a phase toggles at wrap. Each TCK bit is CLK_DIV cycles low followed by CLK_DIV cycles high. TCK runs only while a bit is in progress and idles low.
- Per bit: TMS/TDI are updated on the clk edge that drives tck_o low. tdo_i is registered on the clk edge that drives tck_o high, so the sample is taken before the TAP's rising-edge update.
- FSM states: INIT, IDLE, RST_SEQ, HDR, SHIFT, TAIL, RUNIDLE, RESP.
  - INIT: entered from reset. Issues 5 TMS=1 bits, then 1 TMS=0 bit, leaving the TAP in Run-Test/Idle. Then moves to IDLE.
  - IDLE: cmd_ready_o=1. A handshake latches type, length and data. Length is clamped to MAX_LEN.
  - Type 00 → RST_SEQ: same 6-bit sequence as INIT.
  - Type 01 → HDR: TMS 1,1,0,0. Type 10 → HDR: TMS 1,0,0.
  - SHIFT: len bits, TDI=data[i]. TMS=0 except on the last bit, where TMS=1 (enters Exit1). Sampled TDO is shifted in from the MSB side.
  - TAIL: TMS 1 then 0 (Update, then Run-Test/Idle).
  - Type 11 → RUNIDLE: len bits with TMS=0, TDI=0.
  - After any command: RESP. Holds rsp_valid_o until rsp_ready_i, then returns to IDLE.
- rsp_data_o is right-aligned: the shift register is shifted right by MAX_LEN-len at the end of SHIFT. Bits ≥len are 0. Non-scan commands return 0.
- Scan with len=0: no TCK toggling at all, including no header. Goes straight to RESP with data 0.
- Idle with len=0: same behaviour, straight to RESP with data 0.
- tdi_o=0 whenever not in SHIFT.

## Timing
- Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=1 (INIT pending).
- cmd_ready_o first rises 6·2·CLK_DIV (+1) clk cycles after reset release.
- Command latency in TCKs:
  - IR scan: 4+len+2.
  - DR scan: 3+len+2.
  - Reset: 6.
  - Idle: len.
- Each TCK is 2·CLK_DIV clk cycles. rsp_valid_o rises 1 clk after the final TCK falling edge.
- cmd_ready_o is 0 from the accepting edge until the response handshake completes. Only one command is in flight.
- rsp_valid_o/rsp_data_o are stable while rsp_valid_o=1 and rsp_ready_i=0.
- ntrst_i assertion mid-command aborts immediately: outputs take reset values, the response is lost, and INIT reruns on release.

## Test plan
- Reset release, TAP model with IDCODE=0x1DEAD3FF, CLK_DIV=2 → 6 TCKs of period 4 clk, TMS sequence 111110, then cmd_ready_o=1.
- IR scan len 5, data 0x01 → rsp 0x01. Then DR scan len 32, data 0 → rsp 0x1DEAD3FF.
- IR 0x10 → DR scan len 32 → rsp 0x00000071 (DTMCS).
- IR 0x11, DR scan len 41 writing 0x0AB_CDEF_0123. A second DR scan len 41 then returns 0x0AB_CDEF_0123.
- IR 0x1F (bypass), DR scan len 8, data 0xA5 → rsp 0x4A (one-bit delay). Also verify len 0 produces no TCK and rsp 0.
- ntrst_i pulsed mid-SHIFT of a 32-bit scan → tck_o=0, rsp_valid_o=0 at once; INIT reruns; hold rsp_ready_i=0 on a later command and check the response is held stable.

Source files
------------

// File: rtl/jtag_master.sv
// Host-side JTAG driver: walks the TAP through reset, IR/DR scans and idle cycles,
// generating TCK/TMS/TDI from a clock divider and returning right-aligned TDO data.
module jtag_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 64
) (
    input  logic               clk_i,
    input  logic               ntrst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_type_i,
    input  logic [6:0]         cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i,
    output logic               busy_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
    localparam logic [1:0] TYPE_RST = 2'b00;
    localparam logic [1:0] TYPE_IR = 2'b01;
    localparam logic [1:0] TYPE_IDLE = 2'b11;

    typedef enum logic [2:0] {INIT, IDLE, RST_SEQ, HDR, SHIFT, TAIL, RUNIDLE, RESP} state_e;

    state_e             state_q, state_d;
    logic [1:0]         type_q, type_d;
    logic [6:0]         len_q, len_d;
    logic [6:0]         bit_cnt_q, bit_cnt_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               active_q, active_d;
    logic               phase_q, phase_d;
    logic [DW-1:0]      div_q, div_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               tdo_q, tdo_d;

    logic               bit_end, next_bit, issue, issue_tms, issue_tdi;
    logic [6:0]         hdr_len, cmd_len_clamped;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        sr_d       = sr_q;
        rsp_data_d = rsp_data_q;
        active_d   = active_q;
        phase_d    = phase_q;
        div_d      = div_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        tdo_d      = tdo_q;
        issue      = 1'b0;
        issue_tms  = 1'b0;
        issue_tdi  = 1'b0;
        hdr_len    = (type_q == TYPE_IR) ? 7'd4 : 7'd3;
        cmd_len_clamped = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;

        bit_end  = active_q && phase_q && (div_q == DIV_LAST);
        next_bit = !active_q || bit_end;

        // TCK engine: low half, sample TDO on the rising edge, end bit on the falling edge
        if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                    tck_d   = 1'b1;
                    tdo_d   = tdo_i;
                end else begin
                    phase_d  = 1'b0;
                    tck_d    = 1'b0;
                    active_d = 1'b0;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (bit_end && state_q == SHIFT) begin
            sr_d = {tdo_q, sr_q[MAX_LEN-1:1]};
        end

        case (state_q)
            INIT, RST_SEQ: begin
                if (next_bit) begin
                    if (bit_cnt_q < 7'd6) begin
                        issue     = 1'b1;
                        issue_tms = (bit_cnt_q < 7'd5);
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end else if (!active_q) begin
                        state_d    = (state_q == INIT) ? IDLE : RESP;
                        rsp_data_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
            end
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    type_d    = cmd_type_i;
                    len_d     = cmd_len_clamped;
                    data_d    = cmd_data_i;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                    if (cmd_type_i == TYPE_RST) begin
                        state_d = RST_SEQ;
                    end else if (cmd_len_clamped == 7'd0) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                    end else if (cmd_type_i == TYPE_IDLE) begin
                        state_d = RUNIDLE;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (next_bit) begin
                    issue = 1'b1;
                    if (bit_cnt_q < hdr_len) begin
                        issue_tms = (bit_cnt_q == 7'd0) || (type_q == TYPE_IR && bit_cnt_q == 7'd1);
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end else begin
                        // First data bit follows the header with no gap in TCK
                        state_d   = SHIFT;
                        issue_tms = (len_q == 7'd1);
                        issue_tdi = data_q[0];
                        data_d    = data_q >> 1;
                        bit_cnt_d = 7'd1;
                    end
                end
            end
            SHIFT: begin
                if (next_bit) begin
                    issue = 1'b1;
                    if (bit_cnt_q < len_q) begin
                        issue_tms = (bit_cnt_q == len_q - 7'd1);
                        issue_tdi = data_q[0];
                        data_d    = data_q >> 1;
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end else begin
                        state_d   = TAIL;
                        issue_tms = 1'b1;
                        bit_cnt_d = 7'd1;
                    end
                end
            end
            TAIL: begin
                if (next_bit) begin
                    if (bit_cnt_q < 7'd2) begin
                        issue     = 1'b1;
                        issue_tms = (bit_cnt_q == 7'd0);
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end else if (!active_q) begin
                        state_d    = RESP;
                        rsp_data_d = sr_q >> (LEN_MAX - len_q);
                        bit_cnt_d  = '0;
                    end
                end
            end
            RUNIDLE: begin
                if (next_bit) begin
                    if (bit_cnt_q < len_q) begin
                        issue     = 1'b1;
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end else if (!active_q) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase

        if (issue) begin
            active_d = 1'b1;
            div_d    = '0;
            phase_d  = 1'b0;
            tck_d    = 1'b0;
            tms_d    = issue_tms;
            tdi_d    = issue_tdi;
        end

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // Reset leaves the first INIT bit (TMS=1) already in progress
    always_ff @(posedge clk_i or negedge ntrst_i) begin
        if (!ntrst_i) begin
            state_q     <= INIT;
            type_q      <= '0;
            len_q       <= '0;
            bit_cnt_q   <= 7'd1;
            data_q      <= '0;
            sr_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            active_q    <= 1'b1;
            phase_q     <= 1'b0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            tdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            len_q       <= len_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            sr_q        <= sr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            active_q    <= active_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            tdo_q       <= tdo_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule
